// File: rtl/nmes_stim_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nmes_stim_pkg
// Purpose  : Shared types and helpers for the NMES biphasic pulse sequencer:
//            phase-state encoding, default phase lengths, rest-length and
//            counter-width helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package nmes_stim_pkg;

  // Phase FSM encoding (3 bits covers the six states).
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CAT  = 3'd1,
    ST_GAP  = 3'd2,
    ST_ANO  = 3'd3,
    ST_DIS  = 3'd4,
    ST_REST = 3'd5
  } state_t;

  // Default phase lengths in 1 us system-clock cycles.
  localparam int c_def_num_ch     = 4;
  localparam int c_def_mag_w      = 5;
  localparam int c_def_period     = 500;
  localparam int c_def_cat_phase  = 150;
  localparam int c_def_ipd        = 10;
  localparam int c_def_ano_phase  = 150;
  localparam int c_def_dis_phase  = 10;
  localparam int c_def_mag_target = 10;
  localparam int c_def_ramp_step  = 1;
  localparam int c_def_dwell      = 5;
  localparam int c_def_blank_pre  = 5;
  localparam int c_def_blank_post = 20;

  // Cycles left in the period once the active pulse phases are done.
  function automatic int f_rest_len(input int period, input int cat,
                                    input int ipd, input int ano, input int dis);
    return period - (cat + ipd + ano + dis);
  endfunction

  // Bit width needed to hold values 0..n-1, never less than one bit.
  function automatic int f_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/nmes_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nmes_ramp_ctrl
// Purpose  : Per-pulse magnitude ramp, dwell counter and channel pointer.
//            Everything advances only on the one-cycle pulse-start strobe, so
//            the outputs are stable for the whole pulse and held in between.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            i_start         - pulse-start strobe (edge that enters CAT)
//            i_restart       - pulse starts from IDLE: reset dwell and ramp
//            i_ramp, i_sweep - mode bits sampled on i_start
//            i_ch_start      - fixed channel / sweep start channel
//            o_ch, o_mag     - registered channel select and magnitude code
// Revision : 1.0 - initial release
// ============================================================================
module nmes_ramp_ctrl
  import nmes_stim_pkg::*;
#(
  parameter int NUM_CH     = c_def_num_ch,
  parameter int MAG_W      = c_def_mag_w,
  parameter int MAG_TARGET = c_def_mag_target,
  parameter int RAMP_STEP  = c_def_ramp_step,
  parameter int DWELL      = c_def_dwell
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic                      i_restart,
  input  logic                      i_ramp,
  input  logic                      i_sweep,
  input  logic [$clog2(NUM_CH)-1:0] i_ch_start,
  output logic [$clog2(NUM_CH)-1:0] o_ch,
  output logic [MAG_W-1:0]          o_mag
);

  localparam int c_chw = $clog2(NUM_CH);
  localparam int c_dw  = f_width(DWELL + 1);
  localparam int c_mw1 = MAG_W + 1;

  localparam logic [MAG_W-1:0] c_target  = MAG_W'(MAG_TARGET);
  localparam logic [MAG_W-1:0] c_first   = MAG_W'((RAMP_STEP < MAG_TARGET) ? RAMP_STEP : MAG_TARGET);
  localparam logic [c_mw1-1:0] c_step    = c_mw1'(RAMP_STEP);
  localparam logic [c_dw-1:0]  c_dwell   = c_dw'(DWELL);
  localparam logic [c_dw-1:0]  c_one     = c_dw'(1);
  localparam logic [c_chw-1:0] c_last_ch = c_chw'(NUM_CH - 1);

  logic [c_dw-1:0]  r_dwell;    // pulses delivered on the current channel
  logic [c_chw-1:0] w_ch;
  logic [MAG_W-1:0] w_mag;
  logic [c_dw-1:0]  w_dwell;
  logic [c_mw1-1:0] w_sum;      // one extra bit so saturation never wraps
  logic             w_adv;
  logic             w_new_ch;

  always_comb begin
    w_sum    = {1'b0, o_mag} + c_step;
    w_adv    = i_sweep && !i_restart && (r_dwell >= c_dwell);
    w_new_ch = i_restart || w_adv;

    w_ch = o_ch;
    if (i_restart || !i_sweep) begin
      w_ch = i_ch_start;
    end else if (w_adv) begin
      w_ch = (o_ch == c_last_ch) ? '0 : o_ch + c_chw'(1);
    end

    if (!i_ramp) begin
      w_mag = c_target;
    end else if (w_new_ch) begin
      w_mag = c_first;
    end else if (w_sum >= {1'b0, c_target}) begin
      w_mag = c_target;
    end else begin
      w_mag = w_sum[MAG_W-1:0];
    end

    // Saturate at DWELL so fixed-channel runs never overflow the counter.
    if (w_new_ch) begin
      w_dwell = c_one;
    end else if (r_dwell >= c_dwell) begin
      w_dwell = r_dwell;
    end else begin
      w_dwell = r_dwell + c_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwell <= '0;
      o_ch    <= '0;
      o_mag   <= '0;
    end else if (i_start) begin
      r_dwell <= w_dwell;
      o_ch    <= w_ch;
      o_mag   <= w_mag;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nmes_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : nmes_stim_sequencer
// Purpose  : Biphasic NMES pulse sequencer. Walks CAT -> GAP -> ANO -> DIS ->
//            REST once per PERIOD, drives phase strobes, channel/magnitude and
//            an EMG blanking window. A pulse, once started, always runs to the
//            end of DIS so the electrode charge stays balanced.
// Ports    : CLK, RESET             - clock, asynchronous active-low reset
//            ENABLE                 - run request
//            RAMP_ST, CH_SWEEP_ST   - magnitude ramp / channel sweep modes
//            CH_START               - fixed channel / sweep start channel
//            EN_ST                  - stimulator enable (not IDLE)
//            CAT_ST, ANO_ST, DIS_ST - phase strobes
//            CH_SEL_ST, MAG_ST      - channel select, magnitude code
//            BLANK_EMG              - EMG hold-off window
//            PULSE_DONE             - one-cycle strobe on first REST cycle
// Revision : 1.0 - initial release
// ============================================================================
module nmes_stim_sequencer
  import nmes_stim_pkg::*;
#(
  parameter int NUM_CH     = c_def_num_ch,
  parameter int MAG_W      = c_def_mag_w,
  parameter int PERIOD     = c_def_period,
  parameter int CAT_PHASE  = c_def_cat_phase,
  parameter int IPD        = c_def_ipd,
  parameter int ANO_PHASE  = c_def_ano_phase,
  parameter int DIS_PHASE  = c_def_dis_phase,
  parameter int MAG_TARGET = c_def_mag_target,
  parameter int RAMP_STEP  = c_def_ramp_step,
  parameter int DWELL      = c_def_dwell,
  parameter int BLANK_PRE  = c_def_blank_pre,
  parameter int BLANK_POST = c_def_blank_post
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      ENABLE,
  input  logic                      RAMP_ST,
  input  logic                      CH_SWEEP_ST,
  input  logic [$clog2(NUM_CH)-1:0] CH_START,
  output logic                      EN_ST,
  output logic                      CAT_ST,
  output logic                      ANO_ST,
  output logic                      DIS_ST,
  output logic [$clog2(NUM_CH)-1:0] CH_SEL_ST,
  output logic [MAG_W-1:0]          MAG_ST,
  output logic                      BLANK_EMG,
  output logic                      PULSE_DONE
);

  localparam int c_active   = CAT_PHASE + IPD + ANO_PHASE + DIS_PHASE;
  localparam int c_rest_len = f_rest_len(PERIOD, CAT_PHASE, IPD, ANO_PHASE, DIS_PHASE);
  localparam int c_cw       = $clog2(PERIOD + 1);

  typedef logic [c_cw-1:0] cnt_t;

  // Down-counter reload values: each state lasts (load + 1) cycles.
  localparam cnt_t c_cat_ld  = cnt_t'(CAT_PHASE - 1);
  localparam cnt_t c_gap_ld  = cnt_t'((IPD > 0) ? IPD - 1 : 0);
  localparam cnt_t c_ano_ld  = cnt_t'(ANO_PHASE - 1);
  localparam cnt_t c_dis_ld  = cnt_t'(DIS_PHASE - 1);
  localparam cnt_t c_rest_ld = cnt_t'(c_rest_len - 1);
  // REST counts down from c_rest_ld: tail window is the top BLANK_POST
  // counts, lead window the bottom BLANK_PRE counts.
  localparam cnt_t c_post_th = cnt_t'((BLANK_POST >= c_rest_len) ? 0 : c_rest_len - BLANK_POST);
  localparam cnt_t c_pre_th  = cnt_t'((BLANK_PRE > c_rest_len) ? c_rest_len : BLANK_PRE);

  generate
    if (c_active >= PERIOD || CAT_PHASE < 1 || ANO_PHASE < 1 || DIS_PHASE < 1 ||
        IPD < 0 || DWELL < 1 || NUM_CH < 2) begin : g_bad_params
      $fatal(1, "nmes_stim_sequencer: invalid phase/period parameters");
    end
  endgenerate

  state_t r_state;
  cnt_t   r_cnt;
  state_t w_nxt_state;
  cnt_t   w_nxt_cnt;
  logic   w_start;
  logic   w_restart;
  logic   w_blank_nxt;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt - cnt_t'(1);
    case (r_state)
      ST_IDLE: begin
        w_nxt_cnt = '0;
        if (ENABLE) begin
          w_nxt_state = ST_CAT;
          w_nxt_cnt   = c_cat_ld;
        end
      end
      ST_CAT: begin
        if (r_cnt == '0) begin
          if (IPD > 0) begin
            w_nxt_state = ST_GAP;
            w_nxt_cnt   = c_gap_ld;
          end else begin
            w_nxt_state = ST_ANO;
            w_nxt_cnt   = c_ano_ld;
          end
        end
      end
      ST_GAP: begin
        if (r_cnt == '0) begin
          w_nxt_state = ST_ANO;
          w_nxt_cnt   = c_ano_ld;
        end
      end
      ST_ANO: begin
        if (r_cnt == '0) begin
          w_nxt_state = ST_DIS;
          w_nxt_cnt   = c_dis_ld;
        end
      end
      ST_DIS: begin
        if (r_cnt == '0) begin
          w_nxt_state = ST_REST;
          w_nxt_cnt   = c_rest_ld;
        end
      end
      ST_REST: begin
        // ENABLE is only consulted here and in IDLE: an active pulse is
        // never cut short.
        if (r_cnt == '0) begin
          if (ENABLE) begin
            w_nxt_state = ST_CAT;
            w_nxt_cnt   = c_cat_ld;
          end else begin
            w_nxt_state = ST_IDLE;
            w_nxt_cnt   = '0;
          end
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase

    w_start   = (w_nxt_state == ST_CAT) && (r_state != ST_CAT);
    w_restart = (r_state == ST_IDLE);

    // Lead window only opens while a follow-on pulse is still requested.
    case (w_nxt_state)
      ST_CAT, ST_GAP, ST_ANO, ST_DIS: w_blank_nxt = 1'b1;
      ST_REST: w_blank_nxt = (w_nxt_cnt >= c_post_th) || (ENABLE && (w_nxt_cnt < c_pre_th));
      default: w_blank_nxt = 1'b0;
    endcase
  end

  // Outputs are decoded from the next state so they align with the state.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      EN_ST      <= 1'b0;
      CAT_ST     <= 1'b0;
      ANO_ST     <= 1'b0;
      DIS_ST     <= 1'b0;
      BLANK_EMG  <= 1'b0;
      PULSE_DONE <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      EN_ST      <= (w_nxt_state != ST_IDLE);
      CAT_ST     <= (w_nxt_state == ST_CAT);
      ANO_ST     <= (w_nxt_state == ST_ANO);
      DIS_ST     <= (w_nxt_state == ST_DIS);
      BLANK_EMG  <= w_blank_nxt;
      PULSE_DONE <= (w_nxt_state == ST_REST) && (r_state == ST_DIS);
    end
  end

  nmes_ramp_ctrl #(
    .NUM_CH     (NUM_CH),
    .MAG_W      (MAG_W),
    .MAG_TARGET (MAG_TARGET),
    .RAMP_STEP  (RAMP_STEP),
    .DWELL      (DWELL)
  ) u_ramp_ctrl (
    .clk        (CLK),
    .rst_n      (RESET),
    .i_start    (w_start),
    .i_restart  (w_restart),
    .i_ramp     (RAMP_ST),
    .i_sweep    (CH_SWEEP_ST),
    .i_ch_start (CH_START),
    .o_ch       (CH_SEL_ST),
    .o_mag      (MAG_ST)
  );

endmodule
`default_nettype wire

// File: tb/tb_nmes_stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_nmes_stim_sequencer
// Purpose  : Self-checking bench for nmes_stim_sequencer. A pulse-timeline
//            reference model predicts every output each cycle and queues it;
//            a monitor on the falling edge pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nmes_stim_sequencer;

  localparam int NUM_CH = 4;
  localparam int MAG_W  = 5;
  localparam int PERIOD = 40;
  localparam int CAT    = 8;
  localparam int IPD    = 2;
  localparam int ANO    = 8;
  localparam int DIS    = 2;
  localparam int TGT    = 10;
  localparam int STEP   = 3;
  localparam int DWELL  = 2;
  localparam int PRE    = 3;
  localparam int POST   = 4;
  localparam int CHW    = 2;
  localparam int ACT    = CAT + IPD + ANO + DIS;

  logic             CLK = 1'b0;
  logic             RESET = 1'b0;
  logic             ENABLE = 1'b0;
  logic             RAMP_ST = 1'b0;
  logic             CH_SWEEP_ST = 1'b0;
  logic [CHW-1:0]   CH_START = '0;
  logic             EN_ST, CAT_ST, ANO_ST, DIS_ST, BLANK_EMG, PULSE_DONE;
  logic [CHW-1:0]   CH_SEL_ST;
  logic [MAG_W-1:0] MAG_ST;

  nmes_stim_sequencer #(
    .NUM_CH(NUM_CH), .MAG_W(MAG_W), .PERIOD(PERIOD), .CAT_PHASE(CAT),
    .IPD(IPD), .ANO_PHASE(ANO), .DIS_PHASE(DIS), .MAG_TARGET(TGT),
    .RAMP_STEP(STEP), .DWELL(DWELL), .BLANK_PRE(PRE), .BLANK_POST(POST)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .RAMP_ST(RAMP_ST),
    .CH_SWEEP_ST(CH_SWEEP_ST), .CH_START(CH_START), .EN_ST(EN_ST),
    .CAT_ST(CAT_ST), .ANO_ST(ANO_ST), .DIS_ST(DIS_ST), .CH_SEL_ST(CH_SEL_ST),
    .MAG_ST(MAG_ST), .BLANK_EMG(BLANK_EMG), .PULSE_DONE(PULSE_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic             en;
    logic             cat;
    logic             ano;
    logic             dis;
    logic             blank;
    logic             done;
    logic [CHW-1:0]   ch;
    logic [MAG_W-1:0] mag;
  } obs_t;

  obs_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // ---------------- reference model: time-within-pulse view ----------------
  bit m_active = 1'b0;
  int m_t = 0;     // cycles since the current CAT began
  int m_n = 0;     // pulses delivered on the current channel
  int m_ch = 0;
  int m_mag = 0;

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  always @(posedge CLK) begin : model
    obs_t e;
    bit   start, from_idle;
    e = '0;
    start = 1'b0;
    from_idle = 1'b0;
    if (!RESET) begin
      m_active = 1'b0; m_t = 0; m_n = 0; m_ch = 0; m_mag = 0;
    end else begin
      if (!m_active) begin
        if (ENABLE) begin m_active = 1'b1; m_t = 0; start = 1'b1; from_idle = 1'b1; end
      end else begin
        m_t++;
        if (m_t == PERIOD) begin
          if (ENABLE) begin m_t = 0; start = 1'b1; end
          else m_active = 1'b0;
        end
      end
      if (start) begin
        if (from_idle || !CH_SWEEP_ST) begin
          if (from_idle) m_n = 1; else m_n++;
          m_ch = int'(CH_START);
        end else if (m_n >= DWELL) begin
          m_ch = (m_ch + 1) % NUM_CH;
          m_n = 1;
        end else begin
          m_n++;
        end
        m_mag = RAMP_ST ? imin(m_n * STEP, TGT) : TGT;
      end
      if (m_active) begin
        e.en    = 1'b1;
        e.cat   = (m_t < CAT);
        e.ano   = (m_t >= CAT + IPD) && (m_t < CAT + IPD + ANO);
        e.dis   = (m_t >= CAT + IPD + ANO) && (m_t < ACT);
        e.done  = (m_t == ACT);
        e.blank = (m_t < ACT + POST) || (ENABLE && ((PERIOD - 1 - m_t) < PRE));
      end
      e.ch  = CHW'(m_ch);
      e.mag = MAG_W'(m_mag);
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin : monitor
    obs_t a, e;
    a = {EN_ST, CAT_ST, ANO_ST, DIS_ST, BLANK_EMG, PULSE_DONE, CH_SEL_ST, MAG_ST};
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL cycle_out @%0t: got %h but no expected entry was queued", $time, a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_out @%0t: got en=%b cat=%b ano=%b dis=%b blank=%b done=%b ch=%0d mag=%0d, want en=%b cat=%b ano=%b dis=%b blank=%b done=%b ch=%0d mag=%0d",
                 $time, a.en, a.cat, a.ano, a.dis, a.blank, a.done, a.ch, a.mag,
                 e.en, e.cat, e.ano, e.dis, e.blank, e.done, e.ch, e.mag);
      end
    end
  end

  // ---------------- directed checks ----------------
  task automatic chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  function automatic int all_outs();
    return int'({EN_ST, CAT_ST, ANO_ST, DIS_ST, BLANK_EMG, PULSE_DONE, CH_SEL_ST, MAG_ST});
  endfunction

  task automatic wait_idle(input string name);
    for (int k = 0; k < 2 * PERIOD + 4 && EN_ST; k++) @(negedge CLK);
    #1;
    chk(name, int'(EN_ST), 0);
  endtask

  task automatic session(input bit ramp, input bit sweep, input int ch,
                         input int cyc, input bit drop_in_ano, input bit rnd);
    @(negedge CLK);
    #2;
    RAMP_ST = ramp; CH_SWEEP_ST = sweep; CH_START = CHW'(ch); ENABLE = 1'b1;
    for (int i = 0; i < cyc; i++) begin
      @(negedge CLK);
      #2;
      if (rnd) begin
        CH_START = CHW'($urandom_range(0, NUM_CH - 1));
        if ($urandom_range(0, 24) == 0) ENABLE = ~ENABLE;
      end
    end
    if (drop_in_ano) begin
      ENABLE = 1'b1;
      for (int k = 0; k < PERIOD + 2 && !ANO_ST; k++) @(negedge CLK);
      #1;
      chk("reach_ano", int'(ANO_ST), 1);
      #1;
    end
    ENABLE = 1'b0;
    wait_idle("idle_after_disable");
    repeat ($urandom_range(2, 10)) @(negedge CLK);
  endtask

  initial begin : stim
    repeat (3) @(negedge CLK);
    #1;
    chk("reset_state", all_outs(), 0);
    @(negedge CLK);
    #2;
    RESET = 1'b1;

    session(1'b0, 1'b0, 2, 130, 1'b1, 1'b0);   // fixed channel 2, drop in ANO
    session(1'b1, 1'b0, 1, 210, 1'b0, 1'b0);   // ramp 3,6,9,10,10
    session(1'b1, 1'b1, 3, 250, 1'b0, 1'b0);   // sweep 3,3,0,0,1,1
    for (int s = 0; s < 4; s++) begin
      bit sw;
      sw = 1'($urandom_range(0, 1));
      session(1'($urandom_range(0, 1)), sw, int'($urandom_range(0, NUM_CH - 1)),
              int'($urandom_range(60, 240)), 1'b0, sw);
    end

    // Reset in the middle of a CAT phase, then ramp must restart.
    @(negedge CLK);
    #2;
    RAMP_ST = 1'b1; CH_SWEEP_ST = 1'b0; CH_START = 2'd1; ENABLE = 1'b1;
    repeat (50) @(negedge CLK);
    for (int k = 0; k < PERIOD + 2 && !CAT_ST; k++) @(negedge CLK);
    @(negedge CLK);
    #1;
    chk("in_cat_before_reset", int'(CAT_ST), 1);
    #1;
    RESET = 1'b0;
    #1;
    chk("reset_mid_cat", all_outs(), 0);
    repeat (2) @(negedge CLK);
    #2;
    RESET = 1'b1;
    for (int k = 0; k < 4 && !CAT_ST; k++) @(negedge CLK);
    #1;
    chk("cat_after_reset", int'(CAT_ST), 1);
    chk("ramp_restart_mag", int'(MAG_ST), STEP);
    repeat (90) @(negedge CLK);
    #2;
    ENABLE = 1'b0;
    wait_idle("idle_final");
    repeat (3) @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
